// File: rtl/register_file_pkg.sv
// Core-wide shared definitions for the integer register file.
// Provides the architectural data width, the register index width, the
// hardwired-zero register index and the matching address/data typedefs.
// Default parameter values of the register file modules come from here.
package register_file_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       reg_data_t;

endpackage

// File: rtl/register_file_checker.sv
// Simulation-only checks for the register file write port.
// Ports:
//   clk, rst - clock and asynchronous active-high reset of the register file
//   regwr    - write enable being monitored
// Flags an unknown write enable whenever the block is out of reset.
module register_file_checker (
    input logic clk,
    input logic rst,
    input logic regwr
);

    // Write enable must be a known value outside reset
    a_regwr_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(regwr));

endmodule

// File: rtl/register_file_read_port.sv
// One combinational read port of the register file.
// Ports:
//   rs      - read address
//   regs    - storage array, entries 1 .. 2**ADDRSIZE-1 (x0 has no storage)
//   wr_en   - qualified write enable (already gated by reset in the top)
//   wr_addr - write address, used only for forwarding
//   wr_data - write data, used only for forwarding
//   rsdata  - read data
// Address 0 always returns zero. With BYPASS=1 a same-cycle write to the
// addressed register is forwarded; x0 is never forwarded.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int ADDRSIZE = REG_ADDR_W,
    parameter int WORDSIZE = XLEN,
    parameter int BYPASS   = 0
)
(
    input  logic [ADDRSIZE-1:0] rs,
    input  logic [WORDSIZE-1:0] regs [1:(2**ADDRSIZE)-1],
    input  logic                wr_en,
    input  logic [ADDRSIZE-1:0] wr_addr,
    input  logic [WORDSIZE-1:0] wr_data,
    output logic [WORDSIZE-1:0] rsdata
);

    logic is_zero_s;
    logic fwd_hit_s;

    // Address decode: x0 detect and forwarding match
    always_comb begin
        is_zero_s = (rs == ADDRSIZE'(REG_ZERO));
        fwd_hit_s = (BYPASS != 0) && wr_en && (wr_addr == rs);
    end

    // Read mux: zero for x0, forwarded data on a hit, else stored value
    always_comb begin
        rsdata = {WORDSIZE{1'b0}};
        if (is_zero_s) begin
            rsdata = {WORDSIZE{1'b0}};
        end else if (fwd_hit_s) begin
            rsdata = wr_data;
        end else begin
            rsdata = regs[rs];
        end
    end

endmodule

// File: rtl/register_file.sv
// Integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero.
// Ports:
//   clk     - clock, writes on rising edge
//   rst     - asynchronous active-high reset, clears all registers
//   regwr   - write enable for rd
//   rs1/rs2 - read addresses
//   rd      - write address (x0 writes are discarded)
//   rddata  - write data, stored verbatim
//   rs1data/rs2data - read data
module register_file
    import register_file_pkg::*;
#(
    parameter int ADDRSIZE = REG_ADDR_W,
    parameter int WORDSIZE = XLEN,
    parameter int BYPASS   = 0
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                regwr,
    input  logic [ADDRSIZE-1:0] rs1,
    input  logic [ADDRSIZE-1:0] rs2,
    input  logic [ADDRSIZE-1:0] rd,
    input  logic [WORDSIZE-1:0] rddata,
    output logic [WORDSIZE-1:0] rs1data,
    output logic [WORDSIZE-1:0] rs2data
);

    localparam int DEPTH = 2**ADDRSIZE;

    logic [WORDSIZE-1:0] regs_r [1:DEPTH-1];
    logic [DEPTH-1:1]    we_s;
    logic                fwd_en_s;

    // Forwarding must not leak write data onto the read ports during reset
    assign fwd_en_s = regwr & ~rst;

    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        // Per-register write decode: an unknown regwr only reaches the addressed entry
        assign we_s[g] = regwr & (rd == ADDRSIZE'(g));

        // Per-register storage with asynchronous clear
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_r[g] <= {WORDSIZE{1'b0}};
            end else if (we_s[g]) begin
                regs_r[g] <= rddata;
            end
        end
    end

    register_file_read_port #(
        .ADDRSIZE (ADDRSIZE),
        .WORDSIZE (WORDSIZE),
        .BYPASS   (BYPASS)
    ) u_rp1 (
        .rs      (rs1),
        .regs    (regs_r),
        .wr_en   (fwd_en_s),
        .wr_addr (rd),
        .wr_data (rddata),
        .rsdata  (rs1data)
    );

    register_file_read_port #(
        .ADDRSIZE (ADDRSIZE),
        .WORDSIZE (WORDSIZE),
        .BYPASS   (BYPASS)
    ) u_rp2 (
        .rs      (rs2),
        .regs    (regs_r),
        .wr_en   (fwd_en_s),
        .wr_addr (rd),
        .wr_data (rddata),
        .rsdata  (rs2data)
    );

    register_file_checker u_chk (
        .clk   (clk),
        .rst   (rst),
        .regwr (regwr)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file (ADDRSIZE=4, WORDSIZE=8).
// Two instances share all inputs: one without and one with forwarding.
module tb_register_file;

    logic       clk;
    logic       rst;
    logic       regwr;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [7:0] rddata;
    logic [7:0] rs1data_nb;
    logic [7:0] rs2data_nb;
    logic [7:0] rs1data_bp;
    logic [7:0] rs2data_bp;

    int vectors;
    int miscompares;

    logic [7:0] model [16];

    register_file #(.ADDRSIZE(4), .WORDSIZE(8), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .regwr(regwr), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rddata(rddata), .rs1data(rs1data_nb), .rs2data(rs2data_nb)
    );

    register_file #(.ADDRSIZE(4), .WORDSIZE(8), .BYPASS(1)) dut_bp (
        .clk(clk), .rst(rst), .regwr(regwr), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rddata(rddata), .rs1data(rs1data_bp), .rs2data(rs2data_bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Architectural view of a read: reset forces zero, x0 is zero,
    // forwarding only in the bypass build, otherwise the last written value.
    function automatic logic [7:0] exp_read(input logic [3:0] a, input bit byp);
        if (rst) return 8'h00;
        if (a == 4'd0) return 8'h00;
        if (byp && regwr && rd == a) return rddata;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst && regwr && rd != 4'd0) model[rd] = rddata;
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, " nb.rs1"}, rs1data_nb, exp_read(rs1, 1'b0));
        chk({tag, " nb.rs2"}, rs2data_nb, exp_read(rs2, 1'b0));
        chk({tag, " bp.rs1"}, rs1data_bp, exp_read(rs1, 1'b1));
        chk({tag, " bp.rs2"}, rs2data_bp, exp_read(rs2, 1'b1));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_model();
        rst = 1'b1; regwr = 1'b0; rs1 = 4'd5; rs2 = 4'd9; rd = 4'd0; rddata = 8'h00;
        #2;
        check_all("reset state");
        chk("reset nb.rs1 const", rs1data_nb, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous clear between edges
        regwr = 1'b1; rd = 4'd5; rddata = 8'hAA;
        step();
        regwr = 1'b0; rs1 = 4'd5;
        check_all("pre-clear");
        chk("pre-clear const", rs1data_nb, 8'hAA);
        #2;
        rst = 1'b1; clear_model();
        check_all("async clear");
        chk("async clear const", rs1data_nb, 8'h00);
        step();
        rst = 1'b0;

        // Fill and readback
        for (int i = 0; i < 16; i++) begin
            regwr = 1'b1; rd = 4'(i); rddata = 8'(15 - i);
            step();
        end
        regwr = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            rs1 = 4'(i); rs2 = 4'(15 - i);
            check_all("fill sweep");
            chk("fill const", rs1data_nb, (i == 0) ? 8'h00 : 8'(15 - i));
        end

        // x0 immunity
        regwr = 1'b1; rd = 4'd0; rddata = 8'hFF;
        check_all("x0 during write");
        step();
        regwr = 1'b0; rs1 = 4'd0; rs2 = 4'd0;
        check_all("x0 readback");
        chk("x0 rs2 const", rs2data_nb, 8'h00);

        // Dual-port independence
        regwr = 1'b1; rd = 4'd3; rddata = 8'h33; step();
        rd = 4'd7; rddata = 8'h77; step();
        regwr = 1'b0; rs1 = 4'd3; rs2 = 4'd7;
        check_all("dual");
        chk("dual rs1 const", rs1data_nb, 8'h33);
        chk("dual rs2 const", rs2data_nb, 8'h77);
        rs1 = 4'd7; rs2 = 4'd3;
        check_all("dual swap");
        chk("swap rs1 const", rs1data_nb, 8'h77);

        // Write enable gating
        regwr = 1'b0; rd = 4'd4; rddata = 8'h5A;
        step(); step(); step();
        rs1 = 4'd4;
        check_all("gating");
        chk("gating const", rs1data_nb, 8'h0B);

        // Read during write
        rs1 = 4'd9; rd = 4'd9; rddata = 8'h42; regwr = 1'b1;
        check_all("rdw before");
        chk("rdw nb before", rs1data_nb, 8'h06);
        chk("rdw bp before", rs1data_bp, 8'h42);
        step();
        regwr = 1'b0;
        check_all("rdw after");
        chk("rdw nb after", rs1data_nb, 8'h42);

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 400; n++) begin
            regwr  = 1'($urandom_range(0, 1));
            rd     = 4'($urandom);
            rddata = 8'($urandom);
            rs1    = ($urandom_range(0, 3) == 0) ? rd : 4'($urandom);
            rs2    = ($urandom_range(0, 3) == 0) ? rd : 4'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                rst = 1'b1;
                clear_model();
            end
            check_all("rand pre");
            step();
            rst = 1'b0;
            check_all("rand post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
